// File: rtl/stream_fifo_link.sv
// stream_fifo_link
// Bridges an FPGA-side valid/ready word stream into a FIFO that the HPS
// drains through a small memory-mapped register window.
//
//   addr | read                          | write
//   -----+-------------------------------+--------------------------------
//   0    | POP head word (0 if empty)    | ignored
//   1    | STATUS {UF,FULL,EMPTY,count}  | ignored
//   2    | STALLS (saturating)           | ignored
//   3    | DEPTH                         | bit0 flush, bit1 clear UF/STALLS
//
// Reads have a fixed latency of one cycle. Every read, and the STATUS
// snapshot in particular, sees the state from before that cycle's push,
// pop and register write.

module stream_fifo_link #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] snk_data,
    input  logic        snk_valid,
    output logic        snk_ready,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ADDR_POP    = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_STALLS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_underflow;
    logic [31:0]   r_stalls;
    logic [31:0]   r_readdata;
    logic          r_readdatavalid;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop_req;
    logic          w_pop;
    logic          w_underflow_set;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clear;
    logic          w_stall;
    logic [31:0]   w_status;
    logic [31:0]   w_rd_mux;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on registered occupancy and reset, never on the
    // HPS side, so a POP cannot open a slot for a push in the same cycle.
    assign snk_ready = !w_full && !reset;

    assign w_push          = snk_valid && snk_ready;
    assign w_pop_req       = avs_read && (avs_address == ADDR_POP);
    assign w_pop           = w_pop_req && !w_empty;
    assign w_underflow_set = w_pop_req && w_empty;

    assign w_ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
    assign w_flush   = w_ctrl_wr && avs_writedata[0];
    assign w_clear   = w_ctrl_wr && avs_writedata[1];

    assign w_stall = snk_valid && !snk_ready;

    // STATUS snapshot assembled from pre-update registered state
    always_comb begin
        w_status            = '0;
        w_status[31]        = r_underflow;
        w_status[17]        = w_full;
        w_status[16]        = w_empty;
        w_status[CW-1:0]    = r_count;
    end

    // Read data select; an empty POP yields zero
    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            ADDR_POP:    w_rd_mux = w_empty ? 32'h0 : r_mem[r_rd_ptr];
            ADDR_STATUS: w_rd_mux = w_status;
            ADDR_STALLS: w_rd_mux = r_stalls;
            ADDR_CTRL:   w_rd_mux = 32'(DEPTH);
            default:     w_rd_mux = '0;
        endcase
    end

    // Storage array; a flush in the same cycle discards the incoming word
    always_ff @(posedge clk) begin
        if (w_push && !w_flush) begin
            r_mem[r_wr_ptr] <= snk_data;
        end
    end

    // Pointers and occupancy; flush overrides any push/pop this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky underflow; a clear write lands at cycle end and so beats a set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (w_clear) begin
            r_underflow <= 1'b0;
        end else if (w_underflow_set) begin
            r_underflow <= 1'b1;
        end
    end

    // Saturating back-pressure counter; clear beats increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stalls <= '0;
        end else if (w_clear) begin
            r_stalls <= '0;
        end else if (w_stall && (r_stalls != 32'hFFFF_FFFF)) begin
            r_stalls <= r_stalls + 32'd1;
        end
    end

    // One-cycle read return; data holds between reads, reset drops the read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= avs_read;
            if (avs_read) begin
                r_readdata <= w_rd_mux;
            end
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_stream_fifo_link.sv
// tb_stream_fifo_link
// Directed scenarios followed by a randomized run, all scored against a
// queue-based model of the FIFO and its register window.

module tb_stream_fifo_link;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    always #5 clk = ~clk;

    stream_fifo_link #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .snk_data          (snk_data),
        .snk_valid         (snk_valid),
        .snk_ready         (snk_ready),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_q[$];
    logic        m_uf;
    logic [31:0] m_stalls;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[31] = m_uf;
        s[17] = (m_q.size() == DEPTH);
        s[16] = (m_q.size() == 0);
        s[CW-1:0] = CW'(m_q.size());
        return s;
    endfunction

    // One clock cycle: drive, check ready, advance model, check read return.
    // Called at posedge+1.
    task automatic step(input logic v, input logic [31:0] d, input logic rd,
                        input logic [1:0] a, input logic wr, input logic [31:0] wd);
        logic        exp_ready;
        logic [31:0] exp_rd;
        reset         = 1'b0;
        snk_valid     = v;
        snk_data      = d;
        avs_read      = rd;
        avs_address   = a;
        avs_write     = wr;
        avs_writedata = wd;
        exp_ready     = (m_q.size() != DEPTH);
        #1;
        chk("snk_ready", 32'(snk_ready), 32'(exp_ready));
        exp_rd = m_rdata;
        if (rd) begin
            case (a)
                2'd0: begin
                    if (m_q.size() > 0) exp_rd = m_q.pop_front();
                    else begin
                        exp_rd = 32'h0;
                        m_uf   = 1'b1;
                    end
                end
                2'd1:    exp_rd = m_status();
                2'd2:    exp_rd = m_stalls;
                default: exp_rd = 32'(DEPTH);
            endcase
        end
        if (v && exp_ready) m_q.push_back(d);
        if (v && !exp_ready && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        if (wr && a == 2'd3) begin
            if (wd[0]) m_q.delete();
            if (wd[1]) begin
                m_uf     = 1'b0;
                m_stalls = 32'h0;
            end
        end
        m_rdata = exp_rd;
        @(posedge clk);
        #1;
        chk("rdvalid", 32'(avs_readdatavalid), 32'(rd));
        chk("rdata", avs_readdata, m_rdata);
    endtask

    task automatic do_reset(input logic rd);
        reset       = 1'b1;
        snk_valid   = 1'b1;
        snk_data    = 32'hDEAD_BEEF;
        avs_read    = rd;
        avs_address = 2'd0;
        avs_write   = 1'b0;
        #1;
        chk("ready_in_reset", 32'(snk_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_q.delete();
        m_uf     = 1'b0;
        m_stalls = 32'h0;
        m_rdata  = 32'h0;
        chk("rst_rdvalid", 32'(avs_readdatavalid), 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
    endtask

    task automatic push(input logic [31:0] d);
        step(1'b1, d, 1'b0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, 32'h0, 1'b1, a, 1'b0, 32'h0);
    endtask

    task automatic wr3(input logic [31:0] wd);
        step(1'b0, 32'h0, 1'b0, 2'd3, 1'b1, wd);
    endtask

    initial begin
        reset = 1'b1; snk_valid = 1'b0; snk_data = '0;
        avs_read = 1'b0; avs_address = '0; avs_write = 1'b0; avs_writedata = '0;
        m_uf = 1'b0; m_stalls = '0; m_rdata = '0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // basic order
        push(32'h11); push(32'h22); push(32'h33);
        rd(2'd0); chk("pop0", avs_readdata, 32'h11);
        rd(2'd0); chk("pop1", avs_readdata, 32'h22);
        rd(2'd0); chk("pop2", avs_readdata, 32'h33);
        rd(2'd1); chk("status_empty", avs_readdata, 32'h0001_0000);
        rd(2'd3); chk("depth", avs_readdata, 32'd16);

        // fill and stall
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i));
        for (int i = 0; i < 5; i++) push(32'hBAD0 + 32'(i));
        chk("ready_full", 32'(snk_ready), 32'h0);
        rd(2'd1); chk("status_full", avs_readdata, 32'h0002_0010);
        rd(2'd2); chk("stalls5", avs_readdata, 32'd5);

        // pop while full with producer waiting; push lands next cycle
        step(1'b1, 32'hAA, 1'b1, 2'd0, 1'b0, 32'h0);
        chk("full_pop_head", avs_readdata, 32'h100);
        push(32'hAA);
        rd(2'd1); chk("status_refull", avs_readdata, 32'h0002_0010);

        // underflow and clear
        wr3(32'h3);
        rd(2'd0); chk("pop_empty", avs_readdata, 32'h0);
        rd(2'd1); chk("status_uf", avs_readdata, 32'h8001_0000);
        wr3(32'h2);
        rd(2'd1); chk("status_cleared", avs_readdata, 32'h0001_0000);
        rd(2'd2); chk("stalls_cleared", avs_readdata, 32'h0);

        // push while empty with simultaneous pop
        step(1'b1, 32'h55, 1'b1, 2'd0, 1'b0, 32'h0);
        chk("pop_push_empty", avs_readdata, 32'h0);
        rd(2'd1); chk("status_pp", avs_readdata, 32'h8000_0001);
        wr3(32'h3);

        // flush with producer active
        for (int i = 0; i < 7; i++) push(32'h200 + 32'(i));
        step(1'b1, 32'hFF, 1'b0, 2'd3, 1'b1, 32'h1);
        rd(2'd1); chk("status_flushed", avs_readdata, 32'h0001_0000);
        push(32'h77);
        rd(2'd0); chk("pop_after_flush", avs_readdata, 32'h77);

        // reset with a read in flight
        for (int i = 0; i < 4; i++) push(32'h300 + 32'(i));
        do_reset(1'b1);
        rd(2'd1); chk("status_after_rst", avs_readdata, 32'h0001_0000);

        // randomized traffic with phases biased toward fill or drain
        for (int blk = 0; blk < 20; blk++) begin
            int push_pct;
            int pop_pct;
            push_pct = (blk % 2 == 0) ? 80 : 25;
            pop_pct  = (blk % 2 == 0) ? 15 : 50;
            for (int c = 0; c < 150; c++) begin
                logic        v;
                logic        r;
                logic        w;
                logic [1:0]  a;
                logic [31:0] wd;
                if ($urandom_range(0, 399) == 0) begin
                    do_reset($urandom_range(0, 1) == 1);
                end else begin
                    v  = ($urandom_range(0, 99) < push_pct);
                    r  = ($urandom_range(0, 99) < pop_pct);
                    a  = (r && $urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(0, 3));
                    w  = ($urandom_range(0, 29) == 0);
                    wd = $urandom;
                    if (w && a == 2'd3 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
                    step(v, $urandom, r, a, w, wd);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
